onehot_expander: RTL and testbench

Inverse of the one-hot-to-index encoder: accepts a binary index command over a valid/ready handshake and emits the corresponding one-hot word on a buffered valid/ready output stream. A sweep command produces a walking-one sequence from the given index up to the MSB. It sits between a control source producing bit indices and consumers that need one-hot select/enable vectors, such as the encoder's input under loopback test.

---
 rtl/onehot_expander.sv | 150 +++++++++++++++
 tb/tb_onehot_expander.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_expander.sv
// onehot_expander
//   Expands a binary bit index into a one-hot word. A command is taken over a
//   valid/ready handshake. It produces either a single one-hot word, a single
//   all-zero word, or a sweep. A sweep is a walking-one run from the given
//   index up to the MSB. Words leave through a small in-order output buffer.
//
// Parameters
//   IDX_W       index width
//   FIFO_DEPTH  output buffer entries (>= 1)
//   OUT_W       one-hot width, 2**IDX_W (derived)
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready           command handshake
//   in_idx, in_sweep, in_zero   command fields
//   out_valid/out_ready         output handshake (buffer head)
//   out_data, out_last          head word, last-word-of-command flag
//   busy                        high while a sweep is being generated
module onehot_expander #(
    parameter  int IDX_W      = 3,
    parameter  int FIFO_DEPTH = 2,
    localparam int OUT_W      = 2 ** IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_idx,
    input  logic             in_sweep,
    input  logic             in_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic             busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [IDX_W-1:0] IDX_MAX = {IDX_W{1'b1}};

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    state_t           state, state_next;
    logic [IDX_W-1:0] cur, cur_next;

    logic             push, pop, full;
    logic [OUT_W-1:0] push_data;
    logic             push_last;

    logic [OUT_W-1:0] data_mem [FIFO_DEPTH];
    logic             last_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Space is judged on the pre-pop count, so a same-cycle pop never
    // makes room for a push.
    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign in_ready  = (state == IDLE) && !full;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign busy      = (state == SWEEP);

    // NOTE: every signal driven here gets a default first, so no path
    // through the branches can leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        cur_next   = cur;
        push       = 1'b0;
        push_data  = '0;
        push_last  = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    push = 1'b1;
                    if (in_zero) begin
                        push_last = 1'b1;
                    end else begin
                        push_data = OUT_W'(1) << in_idx;
                        if (!in_sweep) begin
                            push_last = 1'b1;
                        end else begin
                            push_last = (in_idx == IDX_MAX);
                            if (in_idx != IDX_MAX) begin
                                state_next = SWEEP;
                                cur_next   = in_idx + IDX_W'(1);
                            end
                        end
                    end
                end
            end
            SWEEP: begin
                // Stall in place while the buffer is full.
                if (!full) begin
                    push      = 1'b1;
                    push_data = OUT_W'(1) << cur;
                    push_last = (cur == IDX_MAX);
                    if (cur == IDX_MAX) begin
                        state_next = IDLE;
                    end else begin
                        cur_next = cur + IDX_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cur    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            state <= state_next;
            cur   <= cur_next;
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: buffer storage has no reset; the count gates what is visible,
    // so stale contents after reset are never presented.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= push_data;
            last_mem[wr_ptr] <= push_last;
        end
    end

    assign out_data = out_valid ? data_mem[rd_ptr] : '0;
    assign out_last = out_valid ? last_mem[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_onehot_expander.sv
// tb_onehot_expander
//   Self-checking bench for onehot_expander (IDX_W=3, FIFO_DEPTH=2).
//   Directed scenarios plus a randomized run checked against a word-list
//   model that expands each accepted command into its expected words.
module tb_onehot_expander;

    localparam int IDX_W = 3;
    localparam int OUT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IDX_W-1:0] in_idx = '0;
    logic             in_sweep = 1'b0;
    logic             in_zero = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [OUT_W-1:0] out_data;
    logic             out_last;
    logic             busy;

    int vectors = 0;
    int miscompares = 0;

    // {last, data}
    typedef logic [OUT_W:0] word_t;
    word_t exp_q[$];
    word_t got_q[$];

    onehot_expander #(.IDX_W(IDX_W), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_idx(in_idx), .in_sweep(in_sweep), .in_zero(in_zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    // Inputs change only just after a rising edge, so handshakes seen at the
    // falling edge are exactly the ones that complete on the next rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) got_q.push_back({out_last, out_data});
            if (in_valid && in_ready) begin
                if (in_zero) begin
                    exp_q.push_back({1'b1, 8'h00});
                end else if (!in_sweep) begin
                    exp_q.push_back({1'b1, 8'(1) << in_idx});
                end else begin
                    for (int i = int'(in_idx); i < OUT_W; i++)
                        exp_q.push_back({(i == OUT_W - 1), 8'(1) << i});
                end
            end
        end
    end

    // Present a command (called just after a rising edge); returns just
    // after the rising edge that accepted it.
    task automatic send(input logic [IDX_W-1:0] idx, input logic sw, input logic z);
        int n = 0;
        in_valid = 1'b1; in_idx = idx; in_sweep = sw; in_zero = z;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (!in_ready) begin
            $display("FAIL send_timeout: in_ready=%0b required=1 after %0d cycles", in_ready, n);
            miscompares++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_sweep = 1'b0; in_zero = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL reset_held: out_valid=%0b in_ready=%0b busy=%0b required 0/1/0",
                     out_valid, in_ready, busy);
            miscompares++;
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0 ||
            busy !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL reset_release: valid=%0b data=%h last=%0b busy=%0b ready=%0b required 0/00/0/0/1",
                     out_valid, out_data, out_last, busy, in_ready);
            miscompares++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back_singles;
        out_ready = 1'b1;
        for (int i = 0; i < OUT_W; i++) begin
            in_valid = 1'b1; in_idx = IDX_W'(i); in_sweep = 1'b0; in_zero = 1'b0;
            @(negedge clk);
            vectors++;
            if (in_ready !== 1'b1) begin
                $display("FAIL single_ready idx=%0d: in_ready=%0b required=1", i, in_ready);
                miscompares++;
            end
            if (i > 0) begin
                vectors++;
                if (out_valid !== 1'b1 || out_data !== 8'(1) << (i - 1) || out_last !== 1'b1) begin
                    $display("FAIL single_word idx=%0d: valid=%0b data=%h last=%0b required 1/%h/1",
                             i - 1, out_valid, out_data, out_last, 8'(1) << (i - 1));
                    miscompares++;
                end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'h80 || out_last !== 1'b1) begin
            $display("FAIL single_word idx=7: valid=%0b data=%h last=%0b required 1/80/1",
                     out_valid, out_data, out_last);
            miscompares++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_zero;
        out_ready = 1'b1;
        send(3'd5, 1'b1, 1'b1);
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'h00 || out_last !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL zero_word: valid=%0b data=%h last=%0b busy=%0b required 1/00/1/0",
                     out_valid, out_data, out_last, busy);
            miscompares++;
        end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL zero_single: valid=%0b busy=%0b required 0/0", out_valid, busy);
            miscompares++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sweep;
        logic [7:0] exp_d [3] = '{8'h20, 8'h40, 8'h80};
        out_ready = 1'b1;
        send(3'd5, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || out_data !== exp_d[k] || out_last !== (k == 2) ||
                busy !== (k < 2) || in_ready !== (k == 2)) begin
                $display("FAIL sweep5 step%0d: valid=%0b data=%h last=%0b busy=%0b ready=%0b required 1/%h/%0b/%0b/%0b",
                         k, out_valid, out_data, out_last, busy, in_ready,
                         exp_d[k], k == 2, k < 2, k == 2);
                miscompares++;
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            $display("FAIL sweep5_end: out_valid=%0b required=0", out_valid);
            miscompares++;
        end
        @(posedge clk); #1;
        send(3'd7, 1'b1, 1'b0);
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'h80 || out_last !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL sweep7: valid=%0b data=%h last=%0b busy=%0b required 1/80/1/0",
                     out_valid, out_data, out_last, busy);
            miscompares++;
        end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            $display("FAIL sweep7_single: out_valid=%0b required=0", out_valid);
            miscompares++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        send(3'd2, 1'b0, 1'b0);
        send(3'd4, 1'b0, 1'b0);
        in_valid = 1'b1; in_idx = 3'd6;
        repeat (2) begin
            @(negedge clk);
            vectors++;
            if (in_ready !== 1'b0 || out_data !== 8'h04) begin
                $display("FAIL bp_hold: in_ready=%0b data=%h required 0/04", in_ready, out_data);
                miscompares++;
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (out_data !== 8'h04 || in_ready !== 1'b0) begin
            $display("FAIL bp_first: data=%h in_ready=%0b required 04/0", out_data, in_ready);
            miscompares++;
        end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (out_data !== 8'h10 || in_ready !== 1'b1) begin
            $display("FAIL bp_second: data=%h in_ready=%0b required 10/1", out_data, in_ready);
            miscompares++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'h40 || out_last !== 1'b1) begin
            $display("FAIL bp_third: valid=%0b data=%h last=%0b required 1/40/1",
                     out_valid, out_data, out_last);
            miscompares++;
        end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            $display("FAIL bp_drain: out_valid=%0b required=0", out_valid);
            miscompares++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_sweep;
        int seen = 0;
        got_q.delete();
        exp_q.delete();
        out_ready = 1'b1;
        send(3'd0, 1'b1, 1'b0);
        // 0x01 pops on the next edge, 0x02 on the one after.
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL midrst_async: valid=%0b busy=%0b ready=%0b required 0/0/1",
                     out_valid, busy, in_ready);
            miscompares++;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        vectors++;
        if (seen != 0 || busy !== 1'b0) begin
            $display("FAIL midrst_after: valid_cycles=%0d busy=%0b required 0/0", seen, busy);
            miscompares++;
        end
        vectors++;
        if (got_q.size() != 2 || got_q[0] !== {1'b0, 8'h01} || got_q[1] !== {1'b0, 8'h02}) begin
            $display("FAIL midrst_words: popped=%0d required 2 words 01,02", got_q.size());
            miscompares++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        bit done = 1'b0;
        int n = 0;
        got_q.delete();
        exp_q.delete();
        fork
            begin
                for (int c = 0; c < 150; c++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                    send(IDX_W'($urandom_range(0, OUT_W - 1)),
                         1'($urandom_range(0, 1)),
                         ($urandom_range(0, 5) == 0));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        @(negedge clk);
        while ((busy || out_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (busy || out_valid) begin
            $display("FAIL rand_drain: busy=%0b out_valid=%0b required 0/0", busy, out_valid);
            miscompares++;
        end
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            $display("FAIL rand_count: got=%0d words required=%0d", got_q.size(), exp_q.size());
            miscompares++;
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                $display("FAIL rand_word%0d: got last=%0b data=%h required last=%0b data=%h",
                         i, got_q[i][OUT_W], got_q[i][OUT_W-1:0], exp_q[i][OUT_W], exp_q[i][OUT_W-1:0]);
                miscompares++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back_singles();
        test_zero();
        test_sweep();
        test_backpressure();
        test_reset_mid_sweep();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
